// File: rtl/data_island_scheduler.sv
// Data island scheduler: walks each blanking interval through lead-in control, preamble,
// guard bands and 32-pixel packets, then releases control until the blanking ends.
module data_island_scheduler #(
    parameter int LEAD_CONTROL  = 4,
    parameter int TRAIL_RESERVE = 12,
    parameter int MAX_PACKETS   = 18
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        blank_start,
    input  logic [11:0] blank_len,
    input  logic        packet_pending,
    output logic [1:0]  island_mode,
    output logic        packet_enable,
    output logic [4:0]  packet_pixel_counter,
    output logic [4:0]  packets_sent,
    output logic        sched_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_PREAMBLE, S_LGUARD, S_PACKET, S_TGUARD, S_TAIL
    } state_t;

    localparam logic [1:0]  M_CONTROL  = 2'd0;
    localparam logic [1:0]  M_PREAMBLE = 2'd1;
    localparam logic [1:0]  M_GUARD    = 2'd2;
    localparam logic [1:0]  M_PACKET   = 2'd3;

    localparam logic [11:0] LEAD_LAST  = 12'(LEAD_CONTROL - 1);
    // rem_q counts this cycle, so "pixels left after this cycle" is rem_q - 1
    localparam logic [11:0] ISLAND_MIN = 12'(45 + TRAIL_RESERVE);
    localparam logic [11:0] PACKET_MIN = 12'(35 + TRAIL_RESERVE);
    localparam logic [4:0]  MAX_PK     = 5'(MAX_PACKETS);

    state_t      state_q;
    logic [11:0] rem_q;
    logic [11:0] ph_q;
    logic [4:0]  pix_q;
    logic [4:0]  sent_q;
    logic [1:0]  mode_q;
    logic        err_q;

    logic expiring;
    logic go_island;
    logic go_packet;
    logic lguard_last;
    logic pkt_last;

    assign expiring    = (rem_q <= 12'd1);
    assign go_island   = packet_pending && (rem_q >= ISLAND_MIN);
    assign go_packet   = (sent_q < MAX_PK) && packet_pending && (rem_q >= PACKET_MIN);
    assign lguard_last = (state_q == S_LGUARD) && (ph_q == 12'd1);
    assign pkt_last    = (state_q == S_PACKET) && (pix_q == 5'd31);

    // The strobe must reflect the packet_pending sampled at the decision pixel itself.
    assign packet_enable = !blank_start && !expiring && (lguard_last || (pkt_last && go_packet));

    assign island_mode          = mode_q;
    assign packet_pixel_counter = pix_q;
    assign packets_sent         = sent_q;
    assign sched_error          = err_q;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rem_q   <= 12'd0;
            ph_q    <= 12'd0;
            pix_q   <= 5'd0;
            sent_q  <= 5'd0;
            mode_q  <= M_CONTROL;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (blank_start) begin
                state_q <= S_LEAD;
                rem_q   <= blank_len;
                ph_q    <= 12'd0;
                pix_q   <= 5'd0;
                sent_q  <= 5'd0;
                mode_q  <= M_CONTROL;
                err_q   <= (state_q != S_IDLE);
            end else if (state_q != S_IDLE) begin
                rem_q <= rem_q - 12'd1;
                if (expiring) begin
                    state_q <= S_IDLE;
                    rem_q   <= 12'd0;
                    ph_q    <= 12'd0;
                    pix_q   <= 5'd0;
                    mode_q  <= M_CONTROL;
                end else begin
                    case (state_q)
                        S_LEAD: begin
                            if (ph_q == LEAD_LAST) begin
                                ph_q <= 12'd0;
                                if (go_island) begin
                                    state_q <= S_PREAMBLE;
                                    mode_q  <= M_PREAMBLE;
                                end else begin
                                    state_q <= S_TAIL;
                                end
                            end else begin
                                ph_q <= ph_q + 12'd1;
                            end
                        end
                        S_PREAMBLE: begin
                            if (ph_q == 12'd7) begin
                                state_q <= S_LGUARD;
                                mode_q  <= M_GUARD;
                                ph_q    <= 12'd0;
                            end else begin
                                ph_q <= ph_q + 12'd1;
                            end
                        end
                        S_LGUARD: begin
                            if (ph_q == 12'd1) begin
                                state_q <= S_PACKET;
                                mode_q  <= M_PACKET;
                                ph_q    <= 12'd0;
                                pix_q   <= 5'd0;
                                sent_q  <= sent_q + 5'd1;
                            end else begin
                                ph_q <= ph_q + 12'd1;
                            end
                        end
                        S_PACKET: begin
                            if (pix_q == 5'd31) begin
                                pix_q <= 5'd0;
                                if (go_packet) begin
                                    sent_q <= sent_q + 5'd1;
                                end else begin
                                    state_q <= S_TGUARD;
                                    mode_q  <= M_GUARD;
                                    ph_q    <= 12'd0;
                                end
                            end else begin
                                pix_q <= pix_q + 5'd1;
                            end
                        end
                        S_TGUARD: begin
                            if (ph_q == 12'd1) begin
                                state_q <= S_TAIL;
                                mode_q  <= M_CONTROL;
                                ph_q    <= 12'd0;
                            end else begin
                                ph_q <= ph_q + 12'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler: table of blanking scenarios with hand-computed
// packet counts, plus hand-written restart and mid-island reset sequences.
module tb_data_island_scheduler;

    logic        clk_pixel;
    logic        reset_n;
    logic        blank_start;
    logic [11:0] blank_len;
    logic        packet_pending;
    logic [1:0]  island_mode;
    logic        packet_enable;
    logic [4:0]  packet_pixel_counter;
    logic [4:0]  packets_sent;
    logic        sched_error;

    int n_checks = 0;
    int n_fail   = 0;

    data_island_scheduler dut (
        .clk_pixel            (clk_pixel),
        .reset_n              (reset_n),
        .blank_start          (blank_start),
        .blank_len            (blank_len),
        .packet_pending       (packet_pending),
        .island_mode          (island_mode),
        .packet_enable        (packet_enable),
        .packet_pixel_counter (packet_pixel_counter),
        .packets_sent         (packets_sent),
        .sched_error          (sched_error)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Cycle 0 is the first cycle after the edge that samples blank_start.
    typedef struct {
        int blen;
        int drop;    // first cycle with packet_pending=0 (-1: never)
        bit sparse;  // pending high only on cycles 3 and 45
        int n;       // expected packets in the island
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int pk_end;
        int e_mode, e_pix, e_sent, e_en;
        string tag;
        tag = $sformatf("v%0d", idx);
        pk_end = 14 + 32 * v.n;
        blank_len   = 12'(v.blen);
        blank_start = 1'b1;
        @(posedge clk_pixel);
        #1;
        blank_start = 1'b0;
        for (int c = 0; c < v.blen; c++) begin
            if (v.sparse) packet_pending = (c == 3 || c == 45);
            else          packet_pending = (v.drop < 0 || c < v.drop);
            #1;
            e_mode = 0; e_pix = 0; e_sent = 0; e_en = 0;
            if (v.n > 0) begin
                if      (c < 4)          e_mode = 0;
                else if (c < 12)         e_mode = 1;
                else if (c < 14)         e_mode = 2;
                else if (c < pk_end)     e_mode = 3;
                else if (c < pk_end + 2) e_mode = 2;
                if (e_mode == 3) e_pix = (c - 14) % 32;
                if (c >= 14) e_sent = (c < pk_end) ? (c - 14) / 32 + 1 : v.n;
                if (c == 13) e_en = 1;
                if (e_mode == 3 && e_pix == 31 && (c - 14) / 32 < v.n - 1) e_en = 1;
            end
            chk({tag, "_mode"}, c, int'(island_mode), e_mode);
            chk({tag, "_pix"},  c, int'(packet_pixel_counter), e_pix);
            chk({tag, "_sent"}, c, int'(packets_sent), e_sent);
            chk({tag, "_en"},   c, int'(packet_enable), e_en);
            chk({tag, "_err"},  c, int'(sched_error), 0);
            @(posedge clk_pixel);
            #1;
        end
        packet_pending = 1'b1;
        #1;
        chk({tag, "_idle_mode"}, v.blen, int'(island_mode), 0);
        chk({tag, "_idle_sent"}, v.blen, int'(packets_sent), v.n);
        chk({tag, "_idle_en"},   v.blen, int'(packet_enable), 0);
        @(posedge clk_pixel);
        #1;
        chk({tag, "_hold_sent"}, v.blen + 1, int'(packets_sent), v.n);
    endtask

    task automatic chk_all_zero(input string name, input int cyc);
        chk({name, "_mode"}, cyc, int'(island_mode), 0);
        chk({name, "_en"},   cyc, int'(packet_enable), 0);
        chk({name, "_pix"},  cyc, int'(packet_pixel_counter), 0);
        chk({name, "_sent"}, cyc, int'(packets_sent), 0);
        chk({name, "_err"},  cyc, int'(sched_error), 0);
    endtask

    initial begin
        vecs[0]  = '{blen: 160,  drop: -1, sparse: 1'b0, n: 4};
        vecs[1]  = '{blen: 59,   drop: -1, sparse: 1'b0, n: 0};
        vecs[2]  = '{blen: 60,   drop: -1, sparse: 1'b0, n: 1};
        vecs[3]  = '{blen: 91,   drop: -1, sparse: 1'b0, n: 1};
        vecs[4]  = '{blen: 92,   drop: -1, sparse: 1'b0, n: 2};
        vecs[5]  = '{blen: 1000, drop: -1, sparse: 1'b0, n: 18};
        vecs[6]  = '{blen: 160,  drop: 77, sparse: 1'b0, n: 2};
        vecs[7]  = '{blen: 160,  drop: 0,  sparse: 1'b0, n: 0};
        vecs[8]  = '{blen: 160,  drop: -1, sparse: 1'b1, n: 2};
        vecs[9]  = '{blen: 3,    drop: -1, sparse: 1'b0, n: 0};
        vecs[10] = '{blen: 4,    drop: -1, sparse: 1'b0, n: 0};

        reset_n        = 1'b0;
        blank_start    = 1'b0;
        blank_len      = 12'd0;
        packet_pending = 1'b1;
        repeat (2) @(posedge clk_pixel);
        #1;
        chk_all_zero("reset", -1);
        reset_n = 1'b1;
        @(posedge clk_pixel);
        #1;
        chk_all_zero("post_reset", -1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Restart mid-island: blank_start sampled at old cycle 30 becomes new cycle 0.
        packet_pending = 1'b1;
        blank_len      = 12'd160;
        blank_start    = 1'b1;
        @(posedge clk_pixel);
        #1;
        blank_start = 1'b0;
        repeat (29) @(posedge clk_pixel);
        #1;
        chk("restart_pre_mode", 29, int'(island_mode), 3);
        blank_len   = 12'd100;
        blank_start = 1'b1;
        @(posedge clk_pixel);
        #1;
        blank_start = 1'b0;
        chk("restart_err",  0, int'(sched_error), 1);
        chk("restart_mode", 0, int'(island_mode), 0);
        chk("restart_sent", 0, int'(packets_sent), 0);
        chk("restart_pix",  0, int'(packet_pixel_counter), 0);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk_pixel);
            #1;
            chk("restart_mode", k, int'(island_mode), 0);
            chk("restart_err",  k, int'(sched_error), 0);
        end
        @(posedge clk_pixel);
        #1;
        chk("restart_preamble", 4, int'(island_mode), 1);
        repeat (96) @(posedge clk_pixel);
        #1;
        chk("restart_end_mode", 100, int'(island_mode), 0);
        chk("restart_end_sent", 100, int'(packets_sent), 2);

        // Asynchronous reset in the middle of a packet.
        blank_len   = 12'd160;
        blank_start = 1'b1;
        @(posedge clk_pixel);
        #1;
        blank_start = 1'b0;
        repeat (50) @(posedge clk_pixel);
        #1;
        chk("midreset_pre_mode", 50, int'(island_mode), 3);
        chk("midreset_pre_sent", 50, int'(packets_sent), 2);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset", 50);
        #1;
        reset_n = 1'b1;
        run_vec(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_island_scheduler.md
DATA_ISLAND_SCHEDULER -- requirements
Module: data_island_scheduler

Interface
REQ-001 The block SHALL have parameter LEAD_CONTROL, default 4, giving the number of control-period pixels between blanking start and the data island preamble.
REQ-002 The block SHALL have parameter TRAIL_RESERVE, default 12, giving the minimum number of control pixels that must remain after the trailing guard band.
REQ-003 The block SHALL have parameter MAX_PACKETS, default 18, legal range 1..31, giving the maximum number of packets per island.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk_pixel, input, 1 bit: the pixel clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port blank_start, input, 1 bit: a one-cycle pulse on the first pixel of a blanking interval (cycle 0).
REQ-008 The block SHALL have port blank_len, input, 12 bits: the total number of blanking pixels, sampled when blank_start=1.
REQ-009 The block SHALL have port packet_pending, input, 1 bit: asserted when the packet source holds a non-null packet.
REQ-010 The block SHALL have port island_mode, output, 2 bits, encoded 0=CONTROL, 1=PREAMBLE, 2=GUARD, 3=PACKET.
REQ-011 The block SHALL have port packet_enable, output, 1 bit: a one-cycle strobe telling the packet source to latch the next packet.
REQ-012 The block SHALL have port packet_pixel_counter, output, 5 bits: the pixel index within the current packet.
REQ-013 The block SHALL have port packets_sent, output, 5 bits: the number of packets in the most recent island.
REQ-014 The block SHALL have port sched_error, output, 1 bit: a one-cycle pulse on a protocol violation.

Function
REQ-015 The block SHALL implement states IDLE, LEAD, PREAMBLE, LGUARD, PACKET, TGUARD and TAIL, with all cycle numbers given relative to blank_start at cycle 0.
REQ-016 In IDLE, blank_start SHALL load the remaining-pixel counter with blank_len and enter LEAD; cycle 0 is a LEAD cycle with island_mode=0.
REQ-017 The remaining-pixel counter SHALL decrement by 1 every cycle outside IDLE, and the block SHALL return to IDLE when the counter reaches 0, regardless of state.
REQ-018 On cycle LEAD_CONTROL-1, if packet_pending=1 and blank_len-LEAD_CONTROL >= 56+TRAIL_RESERVE-12, that is >= 44+TRAIL_RESERVE, the block SHALL enter PREAMBLE; otherwise it SHALL enter TAIL.
REQ-019 PREAMBLE SHALL last 8 cycles with island_mode=1.
REQ-020 LGUARD SHALL last 2 cycles with island_mode=2.
REQ-021 PACKET SHALL last 32 cycles per packet with island_mode=3 and packet_pixel_counter counting 0..31.
REQ-022 TGUARD SHALL last 2 cycles with island_mode=2, followed by TAIL with island_mode=0.
REQ-023 packet_enable SHALL assert on the second LGUARD cycle and on packet_pixel_counter=31 of every packet that is followed by another packet.
REQ-024 At packet_pixel_counter=31 of packet k (0-based), the block SHALL continue with another packet only if k+1 < MAX_PACKETS, packet_pending=1, and the pixels remaining after this cycle are >= 34+TRAIL_RESERVE; otherwise it SHALL enter TGUARD.
REQ-025 packet_pending SHALL be ignored at every cycle except the decision points in REQ-018 and REQ-024.
REQ-026 packets_sent SHALL clear on blank_start, increment at each packet's pixel 0, and hold its value until the next blank_start.
REQ-027 blank_start in any non-IDLE state SHALL pulse sched_error for one cycle and restart the sequence at cycle 0 with the new blank_len.
REQ-028 blank_len < LEAD_CONTROL SHALL produce control only and return to IDLE when the remaining-pixel counter expires, with no error.
REQ-029 packet_pixel_counter SHALL read 0 in every state other than PACKET.
REQ-030 The packet counter SHALL be 5 bits wide and SHALL never wrap, because it is bounded by MAX_PACKETS.

Reset
REQ-031 Assertion of reset_n=0 SHALL immediately force IDLE, island_mode=0, packet_enable=0, packet_pixel_counter=0, packets_sent=0, sched_error=0, and clear all counters.
REQ-032 Reset SHALL take effect mid-island with no trailing guard band emitted.
REQ-033 After reset release, the first blank_start SHALL be honoured on the next clock edge.

Verification
REQ-034 Scenario 1: blank_len=160, packet_pending=1, default parameters -> preamble on cycles 4-11, guard on 12-13, 4 packets on 14-141, packet_enable on cycles 13/45/77/109, guard on 142-143, control on 144-159, packets_sent=4.
REQ-035 Scenario 2: blank_len=59 -> control only, packets_sent=0; blank_len=60 -> exactly 1 packet, with the tail of exactly 12 control cycles.
REQ-036 Scenario 3: blank_len=1000, packet_pending=1 -> 18 packets, packets_sent=18, no 19th packet_enable.
REQ-037 Scenario 4: blank_len=160, packet_pending dropped to 0 on cycle 77 -> island ends after 2 packets with TGUARD on cycles 78-79.
REQ-038 Scenario 5: blank_start repeated on cycle 30 of an island -> sched_error=1 on that cycle and island_mode=0 on the next 4 cycles.
REQ-039 Scenario 6: reset_n=0 on cycle 50 of an island -> all outputs are 0 the same cycle, and the next blank_start starts a clean sequence.
